hdmi_period_scheduler: RTL and testbench

- Sequences the three per-channel tmds_encoder instances for HDMI output: decides per pixel slot whether each channel carries control, video preamble, video leading guard band or active video.
- Sits between the video timing generator and the encoders.
- Delays the pixel stream by LEAD slots so that the 8-slot preamble and 2-slot guard band can be placed before each active run using the undelayed DE as lookahead.
- Also flags blanking intervals too short to carry a compliant preamble.

---
 rtl/hdmi_pkg.sv | 19 +
 rtl/hdmi_delay_line.sv | 36 +++
 rtl/hdmi_period_scheduler.sv | 154 +++++++++++++++
 tb/tb_hdmi_period_scheduler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared guard words, preamble control codes and scheduler state encoding
package hdmi_pkg;

    localparam logic [9:0] GUARD_CH0 = 10'b1011001100;
    localparam logic [9:0] GUARD_CH1 = 10'b0100110011;
    localparam logic [9:0] GUARD_CH2 = 10'b1011001100;

    // {CTL3, CTL2, CTL1, CTL0}
    localparam logic [3:0] CTL_PRE_VIDEO = 4'b0001;
    localparam logic [3:0] CTL_PRE_DATA  = 4'b0101;

    typedef enum logic [1:0] {
        ST_CTRL     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_GUARD    = 2'd2,
        ST_VIDEO    = 2'd3
    } sched_state_e;

endpackage

// File: rtl/hdmi_delay_line.sv
// rtl/hdmi_delay_line.sv - enabled shift register of DEPTH stages with async clear
module hdmi_delay_line #(
    parameter int DEPTH = 10,
    parameter int WIDTH = 27
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d = stage_q;
        if (en) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/hdmi_period_scheduler.sv
// rtl/hdmi_period_scheduler.sv - places video preamble and guard band ahead of each delayed active run
module hdmi_period_scheduler
    import hdmi_pkg::*;
#(
    parameter int PREAMBLE_LEN = 8,
    parameter int GUARD_LEN    = 2,
    parameter int LEAD         = PREAMBLE_LEN + GUARD_LEN,
    parameter int MIN_BLANK    = 12,
    parameter int DVI_MODE     = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pixel_stb,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [23:0] rgb_in,
    input  logic        err_clr,
    output logic        window,
    output logic [7:0]  d0,
    output logic [7:0]  d1,
    output logic [7:0]  d2,
    output logic        ch0_c0,
    output logic        ch0_c1,
    output logic        ch1_c0,
    output logic        ch1_c1,
    output logic        ch2_c0,
    output logic        ch2_c1,
    output logic        vid_guard,
    output logic        short_blank_err
);

    logic [26:0]  tail;
    sched_state_e state_q, state_d;
    logic [3:0]   slot_cnt_q, slot_cnt_d;
    logic [3:0]   blank_cnt_q, blank_cnt_d;
    logic         de_prev_q, de_prev_d;
    logic         err_q, err_d;
    logic         window_q, window_d;
    logic         guard_q, guard_d;
    logic [3:0]   ctl_q, ctl_d;
    logic [1:0]   sync_q, sync_d;
    logic [23:0]  rgb_q, rgb_d;
    logic         rise, err_set;

    // The tail sample is registered once more below, giving LEAD slots of total delay.
    hdmi_delay_line #(
        .DEPTH(LEAD),
        .WIDTH(27)
    ) u_delay (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (pixel_stb),
        .din    ({de_in, vsync_in, hsync_in, rgb_in}),
        .dout   (tail)
    );

    assign rise = de_in & ~de_prev_q;

    always_comb begin
        state_d     = state_q;
        slot_cnt_d  = slot_cnt_q;
        blank_cnt_d = blank_cnt_q;
        de_prev_d   = de_prev_q;
        window_d    = window_q;
        guard_d     = guard_q;
        ctl_d       = ctl_q;
        sync_d      = sync_q;
        rgb_d       = rgb_q;
        err_set     = 1'b0;
        if (pixel_stb) begin
            de_prev_d   = de_in;
            blank_cnt_d = de_in ? 4'd0 : ((blank_cnt_q == 4'd15) ? 4'd15 : blank_cnt_q + 4'd1);
            unique case (state_q)
                ST_CTRL: begin
                    if (rise && DVI_MODE == 0) begin
                        if (int'(blank_cnt_q) >= MIN_BLANK) begin
                            state_d    = ST_PREAMBLE;
                            slot_cnt_d = 4'd0;
                        end else begin
                            err_set = 1'b1;
                        end
                    end
                end
                ST_PREAMBLE: begin
                    err_set = rise;
                    if (slot_cnt_q == 4'(PREAMBLE_LEN - 1)) begin
                        state_d    = ST_GUARD;
                        slot_cnt_d = 4'd0;
                    end else begin
                        slot_cnt_d = slot_cnt_q + 4'd1;
                    end
                end
                ST_GUARD: begin
                    err_set = rise;
                    if (slot_cnt_q == 4'(GUARD_LEN - 1)) begin
                        state_d    = ST_VIDEO;
                        slot_cnt_d = 4'd0;
                    end else begin
                        slot_cnt_d = slot_cnt_q + 4'd1;
                    end
                end
                ST_VIDEO: begin
                    err_set = rise;
                    if (!tail[26]) begin
                        state_d = ST_CTRL;
                    end
                end
                default: state_d = ST_CTRL;
            endcase
            // Outputs follow the next state so the rise edge already shows preamble.
            window_d = tail[26] & (state_d != ST_GUARD);
            guard_d  = (state_d == ST_GUARD);
            ctl_d    = (state_d == ST_PREAMBLE) ? CTL_PRE_VIDEO : 4'b0000;
            sync_d   = tail[25:24];
            rgb_d    = tail[23:0];
        end
        err_d = err_set | (err_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_CTRL;
            slot_cnt_q  <= '0;
            blank_cnt_q <= '0;
            de_prev_q   <= 1'b0;
            err_q       <= 1'b0;
            window_q    <= 1'b0;
            guard_q     <= 1'b0;
            ctl_q       <= '0;
            sync_q      <= '0;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            slot_cnt_q  <= slot_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            de_prev_q   <= de_prev_d;
            err_q       <= err_d;
            window_q    <= window_d;
            guard_q     <= guard_d;
            ctl_q       <= ctl_d;
            sync_q      <= sync_d;
            rgb_q       <= rgb_d;
        end
    end

    assign window          = window_q;
    assign vid_guard       = guard_q;
    assign {ch2_c1, ch2_c0, ch1_c1, ch1_c0} = ctl_q;
    assign {ch0_c1, ch0_c0} = sync_q;
    assign {d2, d1, d0}    = rgb_q;
    assign short_blank_err = err_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// tb/tb_hdmi_period_scheduler.sv - scoreboard bench for HDMI and DVI builds of the period scheduler
module tb_hdmi_period_scheduler;

    typedef struct packed {
        logic        window;
        logic        vid_guard;
        logic [3:0]  ctl;
        logic [1:0]  hv;
        logic [23:0] rgb;
        logic        err;
    } obs_t;

    typedef struct {
        obs_t main_e;
        obs_t dvi_e;
        int   scen;
        int   edge_n;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pixel_stb = 1'b0;
    logic        de_in = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic [23:0] rgb_in = '0;
    logic        err_clr = 1'b0;

    logic        window_a, ch0_c0_a, ch0_c1_a, ch1_c0_a, ch1_c1_a, ch2_c0_a, ch2_c1_a, guard_a, err_a;
    logic [7:0]  d0_a, d1_a, d2_a;
    logic        window_b, ch0_c0_b, ch0_c1_b, ch1_c0_b, ch1_c1_b, ch2_c0_b, ch2_c1_b, guard_b, err_b;
    logic [7:0]  d0_b, d1_b, d2_b;
    obs_t        obs_a, obs_b;

    int          n_checks = 0;
    int          n_fail = 0;
    int          m = 0;
    int          scen = 0;
    int          pre_ks[$];
    int          err_ks[$];
    logic [26:0] hist [0:255];
    logic        exp_err = 1'b0;
    obs_t        last_a = '0;
    obs_t        last_b = '0;
    exp_t        exp_q[$];
    bit          chk_pending = 1'b0;

    always #5 clk = ~clk;

    hdmi_period_scheduler #(.DVI_MODE(0)) dut (
        .clk(clk), .reset_n(reset_n), .pixel_stb(pixel_stb), .de_in(de_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in), .err_clr(err_clr),
        .window(window_a), .d0(d0_a), .d1(d1_a), .d2(d2_a),
        .ch0_c0(ch0_c0_a), .ch0_c1(ch0_c1_a), .ch1_c0(ch1_c0_a), .ch1_c1(ch1_c1_a),
        .ch2_c0(ch2_c0_a), .ch2_c1(ch2_c1_a), .vid_guard(guard_a), .short_blank_err(err_a)
    );

    hdmi_period_scheduler #(.DVI_MODE(1)) dut_dvi (
        .clk(clk), .reset_n(reset_n), .pixel_stb(pixel_stb), .de_in(de_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in), .err_clr(err_clr),
        .window(window_b), .d0(d0_b), .d1(d1_b), .d2(d2_b),
        .ch0_c0(ch0_c0_b), .ch0_c1(ch0_c1_b), .ch1_c0(ch1_c0_b), .ch1_c1(ch1_c1_b),
        .ch2_c0(ch2_c0_b), .ch2_c1(ch2_c1_b), .vid_guard(guard_b), .short_blank_err(err_b)
    );

    assign obs_a = {window_a, guard_a, ch2_c1_a, ch2_c0_a, ch1_c1_a, ch1_c0_a,
                    ch0_c1_a, ch0_c0_a, d2_a, d1_a, d0_a, err_a};
    assign obs_b = {window_b, guard_b, ch2_c1_b, ch2_c0_b, ch1_c1_b, ch1_c0_b,
                    ch0_c1_b, ch0_c0_b, d2_b, d1_b, d0_b, err_b};

    task automatic check(input string nm, input obs_t act, input obs_t exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got win=%b grd=%b ctl=%b hv=%b rgb=%h err=%b, expected win=%b grd=%b ctl=%b hv=%b rgb=%h err=%b",
                     nm, act.window, act.vid_guard, act.ctl, act.hv, act.rgb, act.err,
                     exp_v.window, exp_v.vid_guard, exp_v.ctl, exp_v.hv, exp_v.rgb, exp_v.err);
        end
    endtask

    // Monitor: one expectation per driven slot, compared half a cycle after the edge.
    always @(negedge clk) begin
        if (chk_pending) begin
            exp_t e;
            chk_pending = 1'b0;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
            end else begin
                e = exp_q.pop_front();
                check($sformatf("s%0d_e%0d_hdmi", e.scen, e.edge_n), obs_a, e.main_e);
                check($sformatf("s%0d_e%0d_dvi", e.scen, e.edge_n), obs_b, e.dvi_e);
            end
        end
    end

    // Drive one clock slot and push what both builds must show after it.
    task automatic slot(input bit stb, input bit de, input bit clr);
        obs_t        ea, eb;
        logic [26:0] dl;
        bit          pre, grd, set;
        exp_t        e;
        @(negedge clk);
        pixel_stb = stb;
        de_in     = de;
        hsync_in  = 1'($urandom);
        vsync_in  = 1'($urandom);
        rgb_in    = 24'($urandom);
        err_clr   = clr;
        ea  = last_a;
        eb  = last_b;
        set = 1'b0;
        e.edge_n = m;
        if (stb) begin
            hist[m] = {de, vsync_in, hsync_in, rgb_in};
            dl  = (m >= 10) ? hist[m-10] : 27'd0;
            pre = 1'b0;
            grd = 1'b0;
            foreach (pre_ks[i]) begin
                if (m >= pre_ks[i] && m <= pre_ks[i] + 7) pre = 1'b1;
                if (m == pre_ks[i] + 8 || m == pre_ks[i] + 9) grd = 1'b1;
            end
            foreach (err_ks[i]) if (m == err_ks[i]) set = 1'b1;
            ea.window    = dl[26] & ~grd;
            ea.vid_guard = grd;
            ea.ctl       = pre ? 4'b0001 : 4'b0000;
            ea.hv        = dl[25:24];
            ea.rgb       = dl[23:0];
            eb           = ea;
            eb.window    = dl[26];
            eb.vid_guard = 1'b0;
            eb.ctl       = 4'b0000;
            eb.err       = 1'b0;
            m++;
        end
        exp_err  = set ? 1'b1 : (clr ? 1'b0 : exp_err);
        ea.err   = exp_err;
        e.main_e = ea;
        e.dvi_e  = eb;
        e.scen   = scen;
        exp_q.push_back(e);
        last_a = ea;
        last_b = eb;
        @(posedge clk);
        chk_pending = 1'b1;
    endtask

    task automatic do_reset(input int s);
        @(negedge clk);
        #2;
        reset_n   = 1'b0;
        pixel_stb = 1'b0;
        de_in     = 1'b0;
        err_clr   = 1'b0;
        #1;
        check($sformatf("reset_s%0d_hdmi", s), obs_a, obs_t'(0));
        check($sformatf("reset_s%0d_dvi", s), obs_b, obs_t'(0));
        @(negedge clk);
        reset_n = 1'b1;
        m       = 0;
        scen    = s;
        pre_ks.delete();
        err_ks.delete();
        exp_err = 1'b0;
        last_a  = '0;
        last_b  = '0;
    endtask

    initial begin
        // 1: long blanking, preamble at 20..27, guard 28..29, window 30..45
        do_reset(1);
        pre_ks.push_back(20);
        repeat (20) slot(1, 0, 0);
        repeat (16) slot(1, 1, 0);
        repeat (15) slot(1, 0, 0);

        // 2: 11-slot blanking flags error; second short rise coincides with err_clr
        do_reset(2);
        err_ks.push_back(11);
        err_ks.push_back(20);
        repeat (11) slot(1, 0, 0);
        repeat (6)  slot(1, 1, 0);
        repeat (3)  slot(1, 0, 0);
        slot(1, 1, 1);
        repeat (2)  slot(1, 1, 0);
        repeat (14) slot(1, 0, 0);
        slot(0, 0, 1);
        repeat (3)  slot(1, 0, 0);

        // 3: exactly 12 blank slots, then a saturated 20-slot gap
        do_reset(3);
        pre_ks.push_back(12);
        pre_ks.push_back(40);
        repeat (12) slot(1, 0, 0);
        repeat (8)  slot(1, 1, 0);
        repeat (20) slot(1, 0, 0);
        repeat (6)  slot(1, 1, 0);
        repeat (16) slot(1, 0, 0);

        // 4: strobe only one clock in three once the run starts
        do_reset(4);
        pre_ks.push_back(13);
        repeat (13) slot(1, 0, 0);
        for (int i = 0; i < 26; i++) begin
            slot(1, (i < 12) ? 1'b1 : 1'b0, 0);
            slot(0, 1'($urandom), 0);
            slot(0, 1'($urandom), 0);
        end

        // 5: reset during guard band, then a rise only 5 slots after release
        do_reset(5);
        pre_ks.push_back(20);
        repeat (20) slot(1, 0, 0);
        repeat (9)  slot(1, 1, 0);
        do_reset(6);
        err_ks.push_back(5);
        repeat (5)  slot(1, 0, 0);
        repeat (5)  slot(1, 1, 0);
        repeat (12) slot(1, 0, 0);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
